// File: rtl/instr_encoder_pkg.sv
// Shared ALU operation codes, MIPS opcode/funct constants
// and the request-to-instruction encoder used by instr_encoder.
package instr_encoder_pkg;

  localparam logic [3:0] ALU_ADDU = 4'd0;
  localparam logic [3:0] ALU_SUBU = 4'd1;
  localparam logic [3:0] ALU_SLT  = 4'd2;
  localparam logic [3:0] ALU_SLTU = 4'd3;
  localparam logic [3:0] ALU_AND  = 4'd4;
  localparam logic [3:0] ALU_OR   = 4'd5;
  localparam logic [3:0] ALU_XOR  = 4'd6;
  localparam logic [3:0] ALU_LUI  = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;
  localparam logic [3:0] ALU_SRL  = 4'd10;
  localparam logic [3:0] ALU_NOR  = 4'd11;
  localparam logic [3:0] ALU_ORI  = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef struct packed {
    logic [3:0]  aluop;
    logic        imm_sel;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [15:0] imm;
  } req_t;

  typedef struct packed {
    logic        legal;
    logic [31:0] word;
  } enc_t;

  // r_ok/i_ok say which form each ALU op may take.
  function automatic enc_t encode(req_t r);
    enc_t       e;
    logic [5:0] fn;
    logic [5:0] op;
    logic       r_ok;
    logic       i_ok;
    logic       shift;
    logic       lui;
    e     = '0;
    fn    = FN_SLL;
    op    = OP_RTYPE;
    r_ok  = 1'b1;
    i_ok  = 1'b1;
    shift = 1'b0;
    lui   = 1'b0;
    unique case (r.aluop)
      ALU_ADDU: begin fn = FN_ADDU; op = OP_ADDIU; end
      ALU_SUBU: begin fn = FN_SUBU; i_ok = 1'b0; end
      ALU_SLT:  begin fn = FN_SLT;  op = OP_SLTI; end
      ALU_SLTU: begin fn = FN_SLTU; op = OP_SLTIU; end
      ALU_AND:  begin fn = FN_AND;  op = OP_ANDI; end
      ALU_OR,
      ALU_ORI:  begin fn = FN_OR;   op = OP_ORI; end
      ALU_XOR:  begin fn = FN_XOR;  op = OP_XORI; end
      ALU_NOR:  begin fn = FN_NOR;  i_ok = 1'b0; end
      ALU_LUI:  begin op = OP_LUI;  lui = 1'b1; r_ok = 1'b0; end
      ALU_SLL:  begin fn = FN_SLL;  shift = 1'b1; i_ok = 1'b0; end
      ALU_SRL:  begin fn = FN_SRL;  shift = 1'b1; i_ok = 1'b0; end
      ALU_SRA:  begin fn = FN_SRA;  shift = 1'b1; i_ok = 1'b0; end
      default:  begin r_ok = 1'b0;  i_ok = 1'b0; end
    endcase
    if (r.imm_sel) begin
      e.legal = i_ok;
      e.word  = {op, lui ? 5'd0 : r.rs, r.rt, r.imm};
    end else begin
      e.legal = r_ok;
      e.word  = {OP_RTYPE,
                 shift ? 5'd0 : r.rs,
                 r.rt, r.rd,
                 shift ? r.shamt : 5'd0,
                 fn};
    end
    return e;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Power-of-two FIFO holding encoded instruction words.
// Head word reads as zero while the FIFO is empty.
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             valid_o,
  output logic             full_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [PW:0]      cnt_q, cnt_d;

  assign valid_o = (cnt_q != '0);
  assign full_o  = (cnt_q == FULL_CNT);
  assign rdata_o = valid_o ? mem_q[rptr_q] : '0;

  // Pointer and occupancy next-state.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push_i) wptr_d = wptr_q + 1'b1;
    if (pop_i)  rptr_d = rptr_q + 1'b1;
    cnt_d = cnt_q + {{PW{1'b0}}, push_i}
                  - {{PW{1'b0}}, pop_i};
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage; a word is written at the accepting edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_i) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Encodes ALU requests into MIPS words, queues them and
// streams them out with an auto-incrementing word address.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_aluop,
  input  logic              in_imm_sel,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [15:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  input  logic              load_base,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              err_illegal,
  output logic [7:0]        drop_cnt
);

  req_t              req;
  enc_t              enc;
  logic              accept;
  logic              push;
  logic              drop;
  logic              pop;
  logic              full;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_q, err_d;
  logic [7:0]        drop_q, drop_d;

  // Gather request fields and encode them.
  always_comb begin
    req.aluop   = in_aluop;
    req.imm_sel = in_imm_sel;
    req.rs      = in_rs;
    req.rt      = in_rt;
    req.rd      = in_rd;
    req.shamt   = in_shamt;
    req.imm     = in_imm;
    enc         = encode(req);
  end

  assign in_ready = rst_n & ~full;
  assign accept   = in_valid & in_ready;
  assign push     = accept & enc.legal;
  assign drop     = accept & ~enc.legal;
  assign pop      = out_valid & out_ready;

  instr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i (enc.word),
    .pop_i   (pop),
    .rdata_o (out_instr),
    .valid_o (out_valid),
    .full_o  (full)
  );

  assign out_addr    = addr_q;
  assign err_illegal = err_q;
  assign drop_cnt    = drop_q;

  // Address counter, error flag and drop counter next-state.
  always_comb begin
    addr_d = addr_q;
    err_d  = err_q;
    drop_d = drop_q;
    if (load_base)  addr_d = base_addr;
    else if (pop)   addr_d = addr_q + ADDR_W'(1);
    if (drop) begin
      err_d = 1'b1;
      if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    end
  end

  // Counter and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      err_q  <= 1'b0;
      drop_q <= '0;
    end else begin
      addr_q <= addr_d;
      err_q  <= err_d;
      drop_q <= drop_d;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios
// plus a randomized run against a queue-based reference model.
module tb_instr_encoder;
  import instr_encoder_pkg::*;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_aluop;
  logic              in_imm_sel;
  logic [4:0]        in_rs, in_rt, in_rd, in_shamt;
  logic [15:0]       in_imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;
  logic              load_base;
  logic [ADDR_W-1:0] base_addr;
  logic              err_illegal;
  logic [7:0]        drop_cnt;

  int checks   = 0;
  int failures = 0;

  int rfn [16];
  int iop [16];

  logic [31:0] q[$];
  int          maddr;
  bit          merr;
  int          mdrop;

  instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_aluop    (in_aluop),
    .in_imm_sel  (in_imm_sel),
    .in_rs       (in_rs),
    .in_rt       (in_rt),
    .in_rd       (in_rd),
    .in_shamt    (in_shamt),
    .in_imm      (in_imm),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_addr    (out_addr),
    .load_base   (load_base),
    .base_addr   (base_addr),
    .err_illegal (err_illegal),
    .drop_cnt    (drop_cnt)
  );

  always #5 clk = ~clk;

  function automatic void init_tables();
    for (int i = 0; i < 16; i++) begin
      rfn[i] = -1;
      iop[i] = -1;
    end
    rfn[ALU_ADDU] = 'h21; rfn[ALU_SUBU] = 'h23;
    rfn[ALU_AND]  = 'h24; rfn[ALU_OR]   = 'h25;
    rfn[ALU_ORI]  = 'h25; rfn[ALU_XOR]  = 'h26;
    rfn[ALU_NOR]  = 'h27; rfn[ALU_SLT]  = 'h2A;
    rfn[ALU_SLTU] = 'h2B; rfn[ALU_SLL]  = 'h00;
    rfn[ALU_SRL]  = 'h02; rfn[ALU_SRA]  = 'h03;
    iop[ALU_ADDU] = 'h09; iop[ALU_SLT]  = 'h0A;
    iop[ALU_SLTU] = 'h0B; iop[ALU_AND]  = 'h0C;
    iop[ALU_OR]   = 'h0D; iop[ALU_ORI]  = 'h0D;
    iop[ALU_XOR]  = 'h0E; iop[ALU_LUI]  = 'h0F;
  endfunction

  function automatic void ref_enc(
    input  logic [3:0]  op,
    input  logic        sel,
    input  logic [4:0]  rs, rt, rd, sh,
    input  logic [15:0] imm,
    output bit          ok,
    output logic [31:0] w);
    bit sft;
    sft = (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    w = 0;
    if (!sel) begin
      ok = rfn[op] >= 0;
      w = (32'(rt) << 16) | (32'(rd) << 11) | 32'(rfn[op] & 63);
      if (sft) w = w | (32'(sh) << 6);
      else     w = w | (32'(rs) << 21);
    end else begin
      ok = iop[op] >= 0;
      w = (32'(iop[op] & 63) << 26) | (32'(rt) << 16) | 32'(imm);
      if (op != ALU_LUI) w = w | (32'(rs) << 21);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic sel,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [4:0] sh,
                       input logic [15:0] imm);
    in_aluop   = op;
    in_imm_sel = sel;
    in_rs      = rs;
    in_rt      = rt;
    in_rd      = rd;
    in_shamt   = sh;
    in_imm     = imm;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 0; out_ready = 0;
    load_base = 0; base_addr = '0;
    drive(ALU_ADDU, 0, 0, 0, 0, 0, 0);
    #2;
    checks++;
    if ({in_ready, out_valid, out_instr, out_addr,
         err_illegal, drop_cnt} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got rdy=%b v=%b i=%h a=%h e=%b d=%0d want all 0",
               in_ready, out_valid, out_instr, out_addr,
               err_illegal, drop_cnt);
    end
    tick();
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready got %b want 1", in_ready);
    end
  endtask

  task automatic test_rtype_addu();
    out_ready = 1;
    drive(ALU_ADDU, 0, 1, 2, 3, 0, 0);
    in_valid = 1;
    tick();
    in_valid = 0;
    checks++;
    if (out_valid !== 1 || out_instr !== 32'h00221821 || out_addr !== 0) begin
      failures++;
      $display("FAIL rtype_addu got v=%b %h @%h want 1 00221821 @000",
               out_valid, out_instr, out_addr);
    end
    tick();
    checks++;
    if (out_valid !== 0) begin
      failures++;
      $display("FAIL rtype_drain got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_itype_shift_lui();
    drive(ALU_ADDU, 1, 4, 5, 0, 0, 16'hFFFF);
    in_valid = 1;
    tick();
    drive(ALU_SLL, 0, 7, 1, 2, 4, 16'h0);
    checks++;
    if (out_valid !== 1 || out_instr !== 32'h2485FFFF || out_addr !== 1) begin
      failures++;
      $display("FAIL itype_addu got v=%b %h @%h want 1 2485ffff @001",
               out_valid, out_instr, out_addr);
    end
    tick();
    drive(ALU_LUI, 1, 3, 8, 0, 0, 16'h1234);
    checks++;
    if (out_valid !== 1 || out_instr !== 32'h00011100 || out_addr !== 2) begin
      failures++;
      $display("FAIL sll got v=%b %h @%h want 1 00011100 @002",
               out_valid, out_instr, out_addr);
    end
    tick();
    in_valid = 0;
    checks++;
    if (out_valid !== 1 || out_instr !== 32'h3C081234 || out_addr !== 3) begin
      failures++;
      $display("FAIL lui got v=%b %h @%h want 1 3c081234 @003",
               out_valid, out_instr, out_addr);
    end
    tick();
  endtask

  task automatic test_full_backpressure();
    logic [31:0] w [5];
    bit          ok;
    bit          acc;
    do_reset();
    out_ready = 0;
    for (int i = 0; i < 5; i++)
      ref_enc(ALU_XOR, 0, 5'(i), 5'(i+1), 5'(i+2), 0, 0, ok, w[i]);
    for (int i = 0; i < 4; i++) begin
      drive(ALU_XOR, 0, 5'(i), 5'(i+1), 5'(i+2), 0, 0);
      in_valid = 1;
      tick();
    end
    drive(ALU_XOR, 0, 5'd4, 5'd5, 5'd6, 0, 0);
    checks++;
    if (in_ready !== 0) begin
      failures++;
      $display("FAIL full_ready got %b want 0", in_ready);
    end
    tick();
    tick();
    checks++;
    if (in_ready !== 0 || out_instr !== w[0] || out_addr !== 0) begin
      failures++;
      $display("FAIL full_hold got rdy=%b %h @%h want 0 %h @000",
               in_ready, out_instr, out_addr, w[0]);
    end
    out_ready = 1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1 || out_instr !== w[i] || out_addr !== 10'(i)) begin
        failures++;
        $display("FAIL drain_%0d got v=%b %h @%h want 1 %h @%0d",
                 i, out_valid, out_instr, out_addr, w[i], i);
      end
      acc = in_valid && in_ready;
      tick();
      if (acc) in_valid = 0;
    end
    checks++;
    if (out_valid !== 0) begin
      failures++;
      $display("FAIL drain_empty got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_illegal_and_wrap();
    drive(ALU_SRA, 1, 1, 2, 3, 4, 16'h5);
    in_valid = 1;
    checks++;
    if (in_ready !== 1) begin
      failures++;
      $display("FAIL illegal_ready got %b want 1", in_ready);
    end
    tick();
    in_valid = 0;
    tick();
    checks++;
    if (out_valid !== 0 || err_illegal !== 1 || drop_cnt !== 8'd1) begin
      failures++;
      $display("FAIL illegal got v=%b e=%b d=%0d want 0 1 1",
               out_valid, err_illegal, drop_cnt);
    end
    load_base = 1;
    base_addr = 10'h3FF;
    tick();
    load_base = 0;
    drive(ALU_AND, 0, 1, 1, 1, 0, 0);
    in_valid = 1;
    tick();
    drive(ALU_OR, 0, 2, 2, 2, 0, 0);
    checks++;
    if (out_valid !== 1 || out_addr !== 10'h3FF) begin
      failures++;
      $display("FAIL base_addr got v=%b @%h want 1 @3ff",
               out_valid, out_addr);
    end
    tick();
    in_valid = 0;
    checks++;
    if (out_valid !== 1 || out_addr !== 10'h000) begin
      failures++;
      $display("FAIL wrap_addr got v=%b @%h want 1 @000",
               out_valid, out_addr);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      drive(ALU_ADDU, 0, 5'(i), 5'(i), 5'(i), 0, 0);
      in_valid = 1;
      tick();
    end
    in_valid = 0;
    rst_n = 0;
    #1;
    checks++;
    if (out_valid !== 0 || in_ready !== 0 || out_instr !== 0 ||
        err_illegal !== 0 || drop_cnt !== 0) begin
      failures++;
      $display("FAIL reset_mid got v=%b rdy=%b i=%h e=%b d=%0d want 0",
               out_valid, in_ready, out_instr, err_illegal, drop_cnt);
    end
    tick();
    rst_n = 1;
    #1;
    checks++;
    if (in_ready !== 1) begin
      failures++;
      $display("FAIL reset_mid_ready got %b want 1", in_ready);
    end
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid !== 0) begin
        failures++;
        $display("FAIL stale_word cyc %0d got v=%b %h", i, out_valid, out_instr);
      end
      tick();
    end
  endtask

  task automatic test_random();
    bit          ok;
    logic [31:0] w;
    bit          acc;
    bit          pop;
    do_reset();
    q.delete();
    maddr = 0;
    merr  = 0;
    mdrop = 0;
    for (int c = 0; c < 600; c++) begin
      checks++;
      if (out_valid !== (q.size() > 0) ||
          in_ready !== (q.size() < DEPTH) ||
          out_addr !== 10'(maddr) ||
          err_illegal !== merr || drop_cnt !== 8'(mdrop) ||
          (q.size() > 0 && out_instr !== q[0])) begin
        failures++;
        $display("FAIL random cyc %0d got v=%b rdy=%b %h @%h e=%b d=%0d want v=%b rdy=%b %h @%h e=%b d=%0d",
                 c, out_valid, in_ready, out_instr, out_addr,
                 err_illegal, drop_cnt, q.size() > 0,
                 q.size() < DEPTH, q.size() > 0 ? q[0] : 32'h0,
                 10'(maddr), merr, mdrop);
      end
      drive(4'($urandom_range(0, 15)), 1'($urandom),
            5'($urandom), 5'($urandom), 5'($urandom),
            5'($urandom), 16'($urandom));
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      load_base = ($urandom_range(0, 19) == 0);
      base_addr = 10'($urandom_range(0, 1023));
      ref_enc(in_aluop, in_imm_sel, in_rs, in_rt, in_rd,
              in_shamt, in_imm, ok, w);
      acc = in_valid && (q.size() < DEPTH);
      pop = out_ready && (q.size() > 0);
      if (pop) begin
        void'(q.pop_front());
        maddr = (maddr + 1) % 1024;
      end
      if (load_base) maddr = int'(base_addr);
      if (acc && ok) q.push_back(w);
      if (acc && !ok) begin
        merr = 1;
        if (mdrop < 255) mdrop++;
      end
      tick();
    end
    in_valid  = 0;
    load_base = 0;
  endtask

  task automatic test_drop_saturation();
    int want;
    out_ready = 1;
    for (int i = 0; i < 6; i++) tick();
    drive(ALU_NOR, 1, 1, 1, 1, 1, 16'h1);
    in_valid = 1;
    for (int i = 0; i < 300; i++) tick();
    in_valid = 0;
    want = (mdrop + 300 > 255) ? 255 : mdrop + 300;
    checks++;
    if (drop_cnt !== 8'(want) || err_illegal !== 1 || out_valid !== 0) begin
      failures++;
      $display("FAIL drop_sat got d=%0d e=%b v=%b want d=%0d e=1 v=0",
               drop_cnt, err_illegal, out_valid, want);
    end
  endtask

  initial begin
    init_tables();
    test_reset();
    test_rtype_addu();
    test_itype_shift_lui();
    test_full_backpressure();
    test_illegal_and_wrap();
    test_reset_mid();
    test_random();
    test_drop_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter DEPTH, default 4: output FIFO entries (power of 2, ≥2).
REQ-002 SHALL have parameter ADDR_W, default 10: instruction-memory word-address width.
REQ-003 SHALL have clk  input  1  the single clock; all state on rising edge.
REQ-004 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have in_valid / in_ready  input / output  1 / 1  request handshake.
REQ-006 SHALL have in_aluop  input  4  ALU operation, using the shared ALUop.vh codes.
REQ-007 SHALL have in_imm_sel  input  1  1 = I-type form, 0 = R-type form.
REQ-008 SHALL have in_rs, in_rt, in_rd, in_shamt  input  5 each  instruction fields.
REQ-009 SHALL have in_imm  input  16  immediate.
REQ-010 SHALL have out_valid / out_ready  output / input  1 / 1  instruction-memory write handshake.
REQ-011 SHALL have out_instr  output  32  encoded MIPS word.
REQ-012 SHALL have out_addr  output  ADDR_W  word address of out_instr.
REQ-013 SHALL have load_base / base_addr  input / input  1 / ADDR_W  address-counter load.
REQ-014 SHALL have err_illegal  output  1  sticky illegal-request flag.
REQ-015 SHALL have drop_cnt  output  8  count of dropped requests, saturating at 255.

Function
REQ-016 SHALL accept a request when in_valid && in_ready; in_ready = (FIFO count < DEPTH), with no same-cycle pass-through from a pop.
REQ-017 SHALL encode R-type as {6'h00, rs, rt, rd, shamt, funct}: ADDU 21, SUBU 23, AND 24, OR 25, XOR 26, NOR 27, SLT 2A, SLTU 2B, SLL 00, SRL 02, SRA 03 (hex); shifts force rs=0; non-shifts force shamt=0.
REQ-018 SHALL encode I-type as {opcode, rs, rt, imm}: ADDU→09, SLT→0A, SLTU→0B, AND→0C, OR/ORI→0D, XOR→0E, LUI→0F with rs forced 0.
REQ-019 SHALL treat ALU_ORI with in_imm_sel=0 as ALU_OR.
REQ-020 SHALL treat as illegal: SUBU/NOR/SLL/SRL/SRA with in_imm_sel=1, LUI with in_imm_sel=0, and any unlisted code; an illegal request SHALL be accepted (handshaked), never written to the FIFO, set err_illegal, and increment drop_cnt.
REQ-021 SHALL write a legal accepted word into the FIFO at the accepting edge; out_valid SHALL rise no earlier than the following cycle (latency 1).
REQ-022 SHALL present the FIFO head on out_instr/out_addr with out_valid = FIFO non-empty; a pop occurs on out_valid && out_ready.
REQ-023 SHALL allow push and pop in the same cycle, leaving count unchanged; a push to a full FIFO SHALL never occur.
REQ-024 SHALL tag each word with the address counter at pop time; the counter SHALL increment by 1 per pop and wrap from 2^ADDR_W−1 to 0.
REQ-025 SHALL, on load_base, set the counter to base_addr; if coincident with a pop, the popped word SHALL use the old address, and the next word SHALL use base_addr.
REQ-026 SHALL hold out_instr/out_addr stable while out_valid && !out_ready.

Reset
REQ-027 SHALL, while rst_n is low, force in_ready=0, out_valid=0, out_instr=0, out_addr=0, err_illegal=0, drop_cnt=0, FIFO empty, counter=0.
REQ-028 SHALL, on reset mid-operation, discard all FIFO contents with no partial word emitted; in_ready SHALL be 1 on the first cycle after release.
REQ-029 SHALL clear err_illegal only by reset.

Structure
REQ-030 SHALL take ALUop codes from the shared ALUop.vh and opcode/funct constants from the shared Opcode.vh; no local literals for these.
REQ-031 SHALL implement the FIFO as sub-module instr_fifo (parameters DEPTH, WIDTH=32+ADDR_W not required; data 32 bits).

Verification
REQ-032 SHALL cover: ADDU, imm_sel=0, rs=1, rt=2, rd=3, out_ready=1 -> out_instr 0x00221821, out_addr 0.
REQ-033 SHALL cover: ADDU, imm_sel=1, rs=4, rt=5, imm=0xFFFF -> 0x2485FFFF; then SLL rd=2, rt=1, shamt=4, rs=7 -> 0x00011100.
REQ-034 SHALL cover: LUI, imm_sel=1, rt=8, imm=0x1234, rs=3 -> 0x3C081234.
REQ-035 SHALL cover: out_ready=0 with 4 pushes -> in_ready=0 after the 4th; 5th request held; out_ready=1 -> 4 words in order at addresses 0..3, then the 5th at 4.
REQ-036 SHALL cover: SRA with imm_sel=1 -> no out_valid, err_illegal=1, drop_cnt=1; load_base=0x3FF then 2 pops -> addresses 0x3FF, 0x000.
REQ-037 SHALL cover: rst_n low with 3 words queued -> out_valid=0 immediately; after release, no stale word is emitted.
